// File: rtl/window_padding_gen.sv
// Streaming 3x3 window generator with zero padding.
// Accepts one raster-ordered frame (HEIGHT x WIDTH) and emits one 3x3 window
// per centre position. A line-buffer shift register holds two rows plus three
// pixels. The taps are masked at the frame borders. After the last pixel, the
// pipe self-flushes with zeros so that the bottom row of windows is produced.
module window_padding_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 5,
    parameter int HEIGHT     = 5,
    parameter int STRIDE     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  valid_in,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] o_data0,
    output logic [DATA_WIDTH-1:0] o_data1,
    output logic [DATA_WIDTH-1:0] o_data2,
    output logic [DATA_WIDTH-1:0] o_data3,
    output logic [DATA_WIDTH-1:0] o_data4,
    output logic [DATA_WIDTH-1:0] o_data5,
    output logic [DATA_WIDTH-1:0] o_data6,
    output logic [DATA_WIDTH-1:0] o_data7,
    output logic [DATA_WIDTH-1:0] o_data8,
    output logic                  o_valid,
    output logic [15:0]           o_row,
    output logic [15:0]           o_col,
    output logic                  frame_done
);

    // Shift register depth: two full rows plus the three taps of the newest row.
    localparam int SR_LEN = 2 * WIDTH + 3;

    // Pixel index whose acceptance completes the first centre (0,0).
    localparam logic [31:0] PIX_FIRST  = 32'(WIDTH + 1);
    localparam logic [31:0] PIX_LAST   = 32'(WIDTH * HEIGHT - 1);
    // The flush lasts WIDTH+1 cycles; the counter runs 0..WIDTH.
    localparam logic [15:0] FLUSH_LAST = 16'(WIDTH);
    localparam logic [15:0] COL_LAST   = 16'(WIDTH - 1);
    localparam logic [15:0] ROW_LAST   = 16'(HEIGHT - 1);
    // The last emitted window.
    // With stride 2 this is the even/even centre with the highest raster index.
    localparam logic [15:0] FD_ROW = (STRIDE == 2) ? 16'(((HEIGHT - 1) / 2) * 2) : ROW_LAST;
    localparam logic [15:0] FD_COL = (STRIDE == 2) ? 16'(((WIDTH - 1) / 2) * 2) : COL_LAST;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                state_q;
    logic [31:0]           pix_q;        // accepted pixels in the current frame
    logic [15:0]           flush_cnt_q;  // flush cycles already spent
    logic [15:0]           wrow_q;       // centre row of the next window to produce
    logic [15:0]           wcol_q;       // centre column of the next window to produce

    logic [DATA_WIDTH-1:0] sr_q   [SR_LEN];
    logic [DATA_WIDTH-1:0] sr_d   [SR_LEN];
    logic [DATA_WIDTH-1:0] tap_d  [9];
    logic [DATA_WIDTH-1:0] taps_q [9];
    logic [8:0]            mask_d;

    logic accept;
    logic shift_en;
    logic produce;
    logic stride_ok;
    logic last_pos;
    logic edge_top;
    logic edge_bot;
    logic edge_lft;
    logic edge_rgt;

    assign in_ready = (state_q != S_FLUSH);
    assign accept   = valid_in && in_ready;
    assign shift_en = accept || (state_q == S_FLUSH);

    // Decide whether this cycle's shift completes a window.
    always_comb begin
        produce = 1'b0;
        case (state_q)
            S_FILL:  produce = accept && (pix_q == PIX_FIRST);
            S_RUN:   produce = accept;
            S_FLUSH: produce = 1'b1;
            default: produce = 1'b0;
        endcase
    end

    // Next shift-register contents: new pixel (or flush zero) enters at sr[0].
    always_comb begin
        sr_d[0] = accept ? i_data : '0;
        for (int i = 1; i < SR_LEN; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    // Window taps are taken after the shift, so the completing pixel is already in sr[0].
    always_comb begin
        tap_d[0] = sr_d[2*WIDTH+2];
        tap_d[1] = sr_d[2*WIDTH+1];
        tap_d[2] = sr_d[2*WIDTH];
        tap_d[3] = sr_d[WIDTH+2];
        tap_d[4] = sr_d[WIDTH+1];
        tap_d[5] = sr_d[WIDTH];
        tap_d[6] = sr_d[2];
        tap_d[7] = sr_d[1];
        tap_d[8] = sr_d[0];
    end

    assign edge_top = (wrow_q == 16'd0);
    assign edge_bot = (wrow_q == ROW_LAST);
    assign edge_lft = (wcol_q == 16'd0);
    assign edge_rgt = (wcol_q == COL_LAST);

    // Border masks.
    // The left and right masks also hide taps that wrapped in from the neighbouring row.
    always_comb begin
        mask_d    = '0;
        mask_d[0] = edge_top | edge_lft;
        mask_d[1] = edge_top;
        mask_d[2] = edge_top | edge_rgt;
        mask_d[3] = edge_lft;
        mask_d[4] = 1'b0;
        mask_d[5] = edge_rgt;
        mask_d[6] = edge_bot | edge_lft;
        mask_d[7] = edge_bot;
        mask_d[8] = edge_bot | edge_rgt;
    end

    assign stride_ok = (STRIDE != 2) || (!wrow_q[0] && !wcol_q[0]);
    assign last_pos  = (wrow_q == FD_ROW) && (wcol_q == FD_COL);

    // Line buffer: shifts on accepted pixels and on every flush cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SR_LEN; i++) begin
                sr_q[i] <= '0;
            end
        end else if (shift_en) begin
            sr_q <= sr_d;
        end
    end

    // Frame control: FILL until the first centre completes, RUN to the last pixel, then FLUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            pix_q       <= '0;
            flush_cnt_q <= '0;
            wrow_q      <= '0;
            wcol_q      <= '0;
        end else begin
            if (produce) begin
                if (wcol_q == COL_LAST) begin
                    wcol_q <= '0;
                    wrow_q <= wrow_q + 16'd1;
                end else begin
                    wcol_q <= wcol_q + 16'd1;
                end
            end
            case (state_q)
                S_FILL: begin
                    if (accept) begin
                        pix_q <= pix_q + 32'd1;
                        if (pix_q == PIX_FIRST) begin
                            state_q <= (pix_q == PIX_LAST) ? S_FLUSH : S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        pix_q <= pix_q + 32'd1;
                        if (pix_q == PIX_LAST) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_q     <= S_FILL;
                        pix_q       <= '0;
                        flush_cnt_q <= '0;
                        wrow_q      <= '0;
                        wcol_q      <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= S_FILL;
                end
            endcase
        end
    end

    // Output register.
    // Taps and coordinates follow every producing shift; valid is filtered by the stride.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                taps_q[k] <= '0;
            end
            o_row      <= '0;
            o_col      <= '0;
            o_valid    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            o_valid    <= produce && stride_ok;
            frame_done <= produce && stride_ok && last_pos;
            if (produce) begin
                for (int k = 0; k < 9; k++) begin
                    taps_q[k] <= mask_d[k] ? '0 : tap_d[k];
                end
                o_row <= wrow_q;
                o_col <= wcol_q;
            end
        end
    end

    assign o_data0 = taps_q[0];
    assign o_data1 = taps_q[1];
    assign o_data2 = taps_q[2];
    assign o_data3 = taps_q[3];
    assign o_data4 = taps_q[4];
    assign o_data5 = taps_q[5];
    assign o_data6 = taps_q[6];
    assign o_data7 = taps_q[7];
    assign o_data8 = taps_q[8];

endmodule

// File: tb/tb_window_padding_gen.sv
// Bench for window_padding_gen.
// Two 4x4 instances share one input stream: one uses stride 1, the other stride 2.
// The model keeps the whole frame as an image and builds each window directly
// from image coordinates, treating out-of-range positions as zero padding.
module tb_window_padding_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int HW = W * H;
    localparam int LR2 = ((H - 1) / 2) * 2;
    localparam int LC2 = ((W - 1) / 2) * 2;

    logic        clk;
    logic        rst;
    logic [31:0] i_data;
    logic        valid_in;

    logic        rdy1, v1, fd1;
    logic [31:0] q1 [9];
    logic [15:0] row1, col1;
    logic        rdy2, v2, fd2;
    logic [31:0] q2 [9];
    logic [15:0] row2, col2;

    window_padding_gen #(.DATA_WIDTH(32), .WIDTH(W), .HEIGHT(H), .STRIDE(1)) dut1 (
        .clk(clk), .rst(rst), .i_data(i_data), .valid_in(valid_in), .in_ready(rdy1),
        .o_data0(q1[0]), .o_data1(q1[1]), .o_data2(q1[2]), .o_data3(q1[3]), .o_data4(q1[4]),
        .o_data5(q1[5]), .o_data6(q1[6]), .o_data7(q1[7]), .o_data8(q1[8]),
        .o_valid(v1), .o_row(row1), .o_col(col1), .frame_done(fd1)
    );

    window_padding_gen #(.DATA_WIDTH(32), .WIDTH(W), .HEIGHT(H), .STRIDE(2)) dut2 (
        .clk(clk), .rst(rst), .i_data(i_data), .valid_in(valid_in), .in_ready(rdy2),
        .o_data0(q2[0]), .o_data1(q2[1]), .o_data2(q2[2]), .o_data3(q2[3]), .o_data4(q2[4]),
        .o_data5(q2[5]), .o_data6(q2[6]), .o_data7(q2[7]), .o_data8(q2[8]),
        .o_valid(v2), .o_row(row2), .o_col(col2), .frame_done(fd2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int errors;
    logic mon_on;

    // Model state.
    int          m_pix;
    int          m_flush;
    logic [31:0] img [HW];
    logic        e_v1, e_v2, e_fd1, e_fd2, e_rdy;
    logic [31:0] e_tap [9];
    int          e_row, e_col;

    // Observed window logs.
    logic [31:0] lg1_tap [128][9];
    int          lg1_row [128];
    int          lg1_col [128];
    logic        lg1_fd  [128];
    logic [31:0] lg2_tap [64][9];
    int          lg2_row [64];
    int          lg2_col [64];
    logic        lg2_fd  [64];
    int          n1, n2, fd1_cnt, fd2_cnt, rdy_low;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d (0x%h), expected %0d", nm, $time, act, act, exp);
        end
    endtask

    function automatic logic [31:0] model_tap(input int r, input int c, input int k);
        int rr, cc;
        rr = r + k / 3 - 1;
        cc = c + k % 3 - 1;
        if (rr < 0 || rr >= H || cc < 0 || cc >= W) return 32'd0;
        return img[rr*W + cc];
    endfunction

    task automatic model_step();
        int k, r, c;
        if (rst) begin
            m_pix = 0; m_flush = 0;
            e_v1 = 0; e_v2 = 0; e_fd1 = 0; e_fd2 = 0;
            e_row = 0; e_col = 0;
            for (int t = 0; t < 9; t++) e_tap[t] = 32'd0;
        end else begin
            k = -1;
            if (m_flush > 0) begin
                k = HW - m_flush;
                m_flush--;
                if (m_flush == 0) m_pix = 0;
            end else if (valid_in) begin
                img[m_pix] = i_data;
                if (m_pix >= W + 1) k = m_pix - (W + 1);
                m_pix++;
                if (m_pix == HW) m_flush = W + 1;
            end
            e_v1 = 0; e_v2 = 0; e_fd1 = 0; e_fd2 = 0;
            if (k >= 0) begin
                r = k / W;
                c = k % W;
                for (int t = 0; t < 9; t++) e_tap[t] = model_tap(r, c, t);
                e_row = r;
                e_col = c;
                e_v1  = 1;
                e_fd1 = (k == HW - 1);
                e_v2  = (r % 2 == 0) && (c % 2 == 0);
                e_fd2 = e_v2 && (r == LR2) && (c == LC2);
            end
        end
        e_rdy = (m_flush == 0);
    endtask

    task automatic compare();
        chk("in_ready", {31'd0, rdy1}, {31'd0, e_rdy});
        chk("in_ready_s2", {31'd0, rdy2}, {31'd0, e_rdy});
        chk("o_valid", {31'd0, v1}, {31'd0, e_v1});
        chk("o_valid_s2", {31'd0, v2}, {31'd0, e_v2});
        chk("frame_done", {31'd0, fd1}, {31'd0, e_fd1});
        chk("frame_done_s2", {31'd0, fd2}, {31'd0, e_fd2});
        if (e_v1) begin
            for (int t = 0; t < 9; t++) chk($sformatf("tap%0d", t), q1[t], e_tap[t]);
            chk("o_row", {16'd0, row1}, 32'(e_row));
            chk("o_col", {16'd0, col1}, 32'(e_col));
        end
        if (e_v2) begin
            for (int t = 0; t < 9; t++) chk($sformatf("tap%0d_s2", t), q2[t], e_tap[t]);
            chk("o_row_s2", {16'd0, row2}, 32'(e_row));
            chk("o_col_s2", {16'd0, col2}, 32'(e_col));
        end
        if (v1 === 1'b1) begin
            if (n1 < 128) begin
                for (int t = 0; t < 9; t++) lg1_tap[n1][t] = q1[t];
                lg1_row[n1] = int'(row1);
                lg1_col[n1] = int'(col1);
                lg1_fd[n1]  = fd1;
            end
            n1++;
            if (fd1 === 1'b1) fd1_cnt++;
        end
        if (v2 === 1'b1) begin
            if (n2 < 64) begin
                for (int t = 0; t < 9; t++) lg2_tap[n2][t] = q2[t];
                lg2_row[n2] = int'(row2);
                lg2_col[n2] = int'(col2);
                lg2_fd[n2]  = fd2;
            end
            n2++;
            if (fd2 === 1'b1) fd2_cnt++;
        end
        if (rdy1 === 1'b0) rdy_low++;
    endtask

    task automatic monitor();
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (mon_on) compare();
        end
    endtask

    // Check one logged window against hand-computed values.
    task automatic chk_win(input string nm, input int which, input int idx, input int r, input int c,
                           input int fd, input int e0, input int e1, input int e2, input int e3,
                           input int e4, input int e5, input int e6, input int e7, input int e8);
        int e [9];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
        e[5] = e5; e[6] = e6; e[7] = e7; e[8] = e8;
        if (which == 1) begin
            chk({nm, "_row"}, 32'(lg1_row[idx]), 32'(r));
            chk({nm, "_col"}, 32'(lg1_col[idx]), 32'(c));
            chk({nm, "_fd"}, {31'd0, lg1_fd[idx]}, 32'(fd));
            for (int t = 0; t < 9; t++) chk($sformatf("%s_t%0d", nm, t), lg1_tap[idx][t], 32'(e[t]));
        end else begin
            chk({nm, "_row"}, 32'(lg2_row[idx]), 32'(r));
            chk({nm, "_col"}, 32'(lg2_col[idx]), 32'(c));
            chk({nm, "_fd"}, {31'd0, lg2_fd[idx]}, 32'(fd));
            for (int t = 0; t < 9; t++) chk($sformatf("%s_t%0d", nm, t), lg2_tap[idx][t], 32'(e[t]));
        end
    endtask

    // Offer pixels base..base+n-1 using the ready handshake; gap=1 drops valid every other cycle.
    task automatic drive(input int base, input int n, input int gap);
        int p, cyc;
        p = 0;
        cyc = 0;
        while (p < n && cyc < 2000) begin
            @(negedge clk);
            if (gap != 0 && cyc[0]) begin
                valid_in = 1'b0;
            end else begin
                valid_in = 1'b1;
                i_data   = 32'(base + p);
                if (rdy1) p++;
            end
            cyc++;
        end
        chk("drive_done", 32'(p), 32'(n));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
        end
    endtask

    initial begin
        int s1, s2, f1, f2, rl, bad;
        rst = 1'b1; valid_in = 1'b0; i_data = 32'd0;
        checks = 0; errors = 0; mon_on = 1'b0;
        n1 = 0; n2 = 0; fd1_cnt = 0; fd2_cnt = 0; rdy_low = 0;
        m_pix = 0; m_flush = 0;
        e_v1 = 0; e_v2 = 0; e_fd1 = 0; e_fd2 = 0; e_rdy = 1; e_row = 0; e_col = 0;
        for (int t = 0; t < 9; t++) e_tap[t] = 32'd0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, rdy1}, 32'd1);
        chk("rst_o_valid", {31'd0, v1}, 32'd0);
        chk("rst_frame_done", {31'd0, fd1}, 32'd0);
        chk("rst_o_row", {16'd0, row1}, 32'd0);
        chk("rst_o_col", {16'd0, col1}, 32'd0);
        for (int t = 0; t < 9; t++) chk($sformatf("rst_tap%0d", t), q1[t], 32'd0);
        rst = 1'b0;
        mon_on = 1'b1;

        // Continuous frame 1..16.
        s1 = n1; s2 = n2; f1 = fd1_cnt; f2 = fd2_cnt; rl = rdy_low;
        drive(1, HW, 0);
        idle(12);
        chk("f1_windows", 32'(n1 - s1), 32'd16);
        chk("f1_frame_done", 32'(fd1_cnt - f1), 32'd1);
        chk("f1_ready_low", 32'(rdy_low - rl), 32'd5);
        chk_win("f1_w00", 1, s1 + 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 5, 6);
        chk_win("f1_w03", 1, s1 + 3, 0, 3, 0, 0, 0, 0, 3, 4, 0, 7, 8, 0);
        chk_win("f1_w11", 1, s1 + 5, 1, 1, 0, 1, 2, 3, 5, 6, 7, 9, 10, 11);
        chk_win("f1_w33", 1, s1 + 15, 3, 3, 1, 11, 12, 0, 15, 16, 0, 0, 0, 0);
        chk("s2_windows", 32'(n2 - s2), 32'd4);
        chk("s2_frame_done", 32'(fd2_cnt - f2), 32'd1);
        chk_win("s2_w00", 2, s2 + 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 5, 6);
        chk("s2_w02_col", 32'(lg2_col[s2 + 1]), 32'd2);
        chk("s2_w20_row", 32'(lg2_row[s2 + 2]), 32'd2);
        chk_win("s2_w22", 2, s2 + 3, 2, 2, 1, 6, 7, 8, 10, 11, 12, 14, 15, 16);

        // Same frame with valid toggling every cycle.
        s1 = n1; f1 = fd1_cnt; rl = rdy_low;
        drive(1, HW, 1);
        idle(12);
        chk("gap_windows", 32'(n1 - s1), 32'd16);
        chk("gap_frame_done", 32'(fd1_cnt - f1), 32'd1);
        chk("gap_ready_low", 32'(rdy_low - rl), 32'd5);
        chk_win("gap_w00", 1, s1 + 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 5, 6);
        chk_win("gap_w11", 1, s1 + 5, 1, 1, 0, 1, 2, 3, 5, 6, 7, 9, 10, 11);

        // Reset after 7 pixels, then a fresh frame 101..116.
        drive(1, 7, 0);
        @(negedge clk);
        valid_in = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s1 = n1;
        drive(101, HW, 0);
        idle(12);
        chk("rst_windows", 32'(n1 - s1), 32'd16);
        chk_win("rst_w00", 1, s1 + 0, 0, 0, 0, 0, 0, 0, 0, 101, 102, 0, 105, 106);
        bad = 0;
        for (int w = 0; w < 16; w++)
            for (int t = 0; t < 9; t++)
                if (lg1_tap[s1 + w][t] >= 32'd1 && lg1_tap[s1 + w][t] <= 32'd7) bad++;
        chk("rst_no_stale", 32'(bad), 32'd0);

        // Two frames back to back: 201..216 then 217..232.
        s1 = n1; f1 = fd1_cnt;
        drive(201, 2 * HW, 0);
        idle(14);
        chk("b2b_windows", 32'(n1 - s1), 32'd32);
        chk("b2b_frame_done", 32'(fd1_cnt - f1), 32'd2);
        chk_win("b2b_a_w00", 1, s1 + 0, 0, 0, 0, 0, 0, 0, 0, 201, 202, 0, 205, 206);
        chk_win("b2b_a_w33", 1, s1 + 15, 3, 3, 1, 211, 212, 0, 215, 216, 0, 0, 0, 0);
        chk_win("b2b_b_w00", 1, s1 + 16, 0, 0, 0, 0, 0, 0, 0, 217, 218, 0, 221, 222);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
